// File: rtl/interconnect_scanner.sv
// interconnect_scanner: sequencer for a registered N-input mux.
//
// Drives the mux sel/clken, stepping through the enabled channels in ascending order.
// Each channel visit is SWITCH (1 cycle), optional SETTLE (settle cycles of blanking),
// then DWELL (max(dwell,1) cycles with valid=1 and tag=sel). valid/tag line up with
// the mux output so downstream logic can demultiplex the shared path.
//
// Optional feature macro: SCANNER_TRIGGER_EN
//   When defined, adds the trig_i input and a WAIT_TRIG state between SETTLE
//   (or SWITCH when settle==0) and DWELL. DWELL starts the cycle after trig_i
//   is sampled high. stop while waiting returns to IDLE with done.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   start_i        pulse: latch config and begin a scan (ignored while busy)
//   stop_i         pulse: finish the current dwell, then return to IDLE
//   continuous_i   1 = wrap forever, 0 = single pass over the enabled channels
//   chan_mask_i    bit i enables channel i
//   settle_i       blanking cycles after each switch (0 = none)
//   dwell_i        valid cycles per channel (0 treated as 1)
//   trig_i         (SCANNER_TRIGGER_EN only) dwell trigger
//   sel_o          mux select
//   clken_o        mux clock enable
//   valid_o        mux output holds settled data of channel tag_o
//   tag_o          channel index qualifying valid_o
//   busy_o         scan in progress
//   done_o         one-cycle pulse on return to IDLE after a pass end or stop

module interconnect_scanner #(
    parameter int unsigned N_INPUTS  = 3,
    parameter int unsigned SEL_WIDTH = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 continuous_i,
    input  logic [N_INPUTS-1:0]  chan_mask_i,
    input  logic [CNT_WIDTH-1:0] settle_i,
    input  logic [CNT_WIDTH-1:0] dwell_i,
`ifdef SCANNER_TRIGGER_EN
    input  logic                 trig_i,
`endif
    output logic [SEL_WIDTH-1:0] sel_o,
    output logic                 clken_o,
    output logic                 valid_o,
    output logic [SEL_WIDTH-1:0] tag_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StSwitch,
        StSettle,
`ifdef SCANNER_TRIGGER_EN
        StWaitTrig,
`endif
        StDwell
    } state_e;

`ifdef SCANNER_TRIGGER_EN
    localparam state_e StPostSettle = StWaitTrig;
`else
    localparam state_e StPostSettle = StDwell;
`endif

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] tag_q, tag_d;
    logic                 clken_q, clken_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stop_q, stop_d;
    logic                 cont_q, cont_d;
    logic [N_INPUTS-1:0]  mask_q, mask_d;
    logic [CNT_WIDTH-1:0] settle_q, settle_d;
    logic [CNT_WIDTH-1:0] dwell_q, dwell_d;

    logic                 nxt_found;
    logic [SEL_WIDTH-1:0] nxt_idx;
    logic [SEL_WIDTH-1:0] low_idx;
    logic [SEL_WIDTH-1:0] first_idx;
    logic [CNT_WIDTH-1:0] dwell_last;
    logic                 stop_pend;

    // Channel search: next enabled above sel_q, lowest enabled (wrap), and the
    // first channel of the incoming mask for a new scan. Descending loop leaves
    // the lowest matching index as the final assignment.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        low_idx   = '0;
        first_idx = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = SEL_WIDTH'(i);
                if (i > int'(sel_q)) begin
                    nxt_found = 1'b1;
                    nxt_idx   = SEL_WIDTH'(i);
                end
            end
            if (chan_mask_i[i]) begin
                first_idx = SEL_WIDTH'(i);
            end
        end
    end

    // Counter holds remaining cycles minus one, so dwell==0 behaves like dwell==1.
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - CNT_WIDTH'(1);
    // A stop arriving on the last dwell cycle still ends the scan there.
    assign stop_pend  = stop_q | stop_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        stop_d   = stop_q;
        cont_d   = cont_q;
        mask_d   = mask_q;
        settle_d = settle_q;
        dwell_d  = dwell_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (start_i && (chan_mask_i != '0)) begin
                    cont_d   = continuous_i;
                    mask_d   = chan_mask_i;
                    settle_d = settle_i;
                    dwell_d  = dwell_i;
                    sel_d    = first_idx;
                    state_d  = StSwitch;
                end
            end
            StSwitch: begin
                if (stop_i) stop_d = 1'b1;
                if (settle_q != '0) begin
                    cnt_d   = settle_q - CNT_WIDTH'(1);
                    state_d = StSettle;
                end else begin
                    cnt_d   = dwell_last;
                    state_d = StPostSettle;
                end
            end
            StSettle: begin
                if (stop_i) stop_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = dwell_last;
                    state_d = StPostSettle;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
`ifdef SCANNER_TRIGGER_EN
            StWaitTrig: begin
                if (stop_pend) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (trig_i) begin
                    state_d = StDwell;
                end
            end
`endif
            StDwell: begin
                if (stop_i) stop_d = 1'b1;
                if (cnt_q == '0) begin
                    if (stop_pend) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (nxt_found) begin
                        sel_d   = nxt_idx;
                        state_d = StSwitch;
                    end else if (cont_q) begin
                        sel_d   = low_idx;
                        state_d = StSwitch;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of the next-state decode.
        clken_d = (state_d != StIdle);
        busy_d  = (state_d != StIdle);
        valid_d = (state_d == StDwell);
        tag_d   = valid_d ? sel_d : tag_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sel_q    <= '0;
            tag_q    <= '0;
            clken_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stop_q   <= 1'b0;
            cont_q   <= 1'b0;
            mask_q   <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            clken_q  <= clken_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            stop_q   <= stop_d;
            cont_q   <= cont_d;
            mask_q   <= mask_d;
            settle_q <= settle_d;
            dwell_q  <= dwell_d;
        end
    end

    assign sel_o   = sel_q;
    assign clken_o = clken_q;
    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_interconnect_scanner.sv
// Testbench for interconnect_scanner: scan timing is predicted from the visit
// arithmetic (period = 1 + settle + max(dwell,1)) and pushed into queues; a
// monitor pops and compares each cycle.
module tb_interconnect_scanner;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int CW = 16;
`ifdef SCANNER_TRIGGER_EN
    localparam int TRIG_CYC = 1;
    logic trig = 1'b1;
`else
    localparam int TRIG_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          cont = 1'b0;
    logic [N-1:0]  mask = '0;
    logic [CW-1:0] settle = '0;
    logic [CW-1:0] dwell = '0;
    logic [SW-1:0] sel_o, tag_o;
    logic          clken_o, valid_o, busy_o, done_o;

    always #5 clk = ~clk;

    interconnect_scanner #(
        .N_INPUTS (N),
        .SEL_WIDTH(SW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .continuous_i(cont),
        .chan_mask_i (mask),
        .settle_i    (settle),
        .dwell_i     (dwell),
`ifdef SCANNER_TRIGGER_EN
        .trig_i      (trig),
`endif
        .sel_o       (sel_o),
        .clken_o     (clken_o),
        .valid_o     (valid_o),
        .tag_o       (tag_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    typedef struct {int cyc; int tag;} vexp_t;
    typedef struct {int s; int e;} scan_t;
    vexp_t vq[$];
    scan_t sq[$];

    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: cycle counter advances on each posedge; outputs sampled 1 time unit later.
    always @(posedge clk) begin
        logic eb, ed;
        vexp_t e;
        cyc = cyc + 1;
        #1;
        eb = (sq.size() > 0) && (cyc >= sq[0].s) && (cyc < sq[0].e);
        ed = (sq.size() > 0) && (cyc == sq[0].e);
        check("busy", 32'(busy_o), 32'(eb));
        check("clken", 32'(clken_o), 32'(eb));
        check("done", 32'(done_o), 32'(ed));
        if (ed) void'(sq.pop_front());
        while (vq.size() > 0 && vq[0].cyc < cyc) begin
            vectors++;
            errors++;
            $display("FAIL missed_valid: valid absent at cyc %0d, expected tag %0d", vq[0].cyc,
                     vq[0].tag);
            void'(vq.pop_front());
        end
        if (valid_o === 1'b1) begin
            if (vq.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_valid @cyc %0d: tag %0d, none expected", cyc, tag_o);
            end else begin
                e = vq.pop_front();
                check("valid_cyc", 32'(cyc), 32'(e.cyc));
                check("tag", 32'(tag_o), 32'(e.tag));
                check("sel", 32'(sel_o), 32'(e.tag));
            end
        end
    end

    // Issue one scan and push its predicted behaviour. stop_sel < 0: no stop.
    task automatic run_scan(input logic [N-1:0] m, input int st, input int dw, input bit c,
                            input int stop_sel, input bit noise, input bit start_stop);
        int en[$];
        int d, p, k, s, e, stop_r;
        for (int i = 0; i < N; i++) if (m[i]) en.push_back(i);
        d = (dw == 0) ? 1 : dw;
        p = 1 + st + TRIG_CYC + d;
        stop_r = (stop_sel < 0) ? -1 : stop_sel % (2 * en.size() * p);
        if (stop_r >= 0) begin
            k = stop_r / p + 1;
            if (!c && k > en.size()) k = en.size();
        end else begin
            k = en.size();
        end
        @(negedge clk);
        mask = m; settle = CW'(st); dwell = CW'(dw); cont = c;
        start = 1'b1;
        stop = start_stop;
        s = cyc + 1;
        e = s + k * p;
        sq.push_back('{s: s, e: e});
        for (int v = 0; v < k; v++)
            for (int j = 0; j < d; j++)
                vq.push_back('{cyc: s + v * p + 1 + st + TRIG_CYC + j, tag: en[v % en.size()]});
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        while (cyc < e + 2) begin
            stop = (stop_r >= 0 && cyc == s + stop_r);
            // Config churn and extra starts while busy must not disturb the scan.
            if (noise && cyc < e - 1 && ($urandom % 4) == 0) begin
                start = 1'b1;
                mask = N'($urandom);
                settle = CW'($urandom_range(0, 5));
                dwell = CW'($urandom_range(0, 5));
                cont = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop = 1'b0;
        check("sel_hold", 32'(sel_o), 32'(en[(k - 1) % en.size()]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two-channel single pass with settle.
        run_scan(3'b101, 2, 4, 1'b0, -1, 1'b0, 1'b0);
        // Continuous, stop during channel 1 of the first round.
        run_scan(3'b111, 0, 0, 1'b1, 2, 1'b0, 1'b0);
        // Empty mask: nothing should happen.
        @(negedge clk);
        mask = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        // Busy start/config changes ignored.
        run_scan(3'b011, 1, 3, 1'b0, -1, 1'b1, 1'b0);
        // Start and stop together in idle: start wins.
        run_scan(3'b110, 1, 2, 1'b0, -1, 1'b0, 1'b1);
        // Single channel continuous wraps through a blank switch cycle.
        run_scan(3'b100, 0, 2, 1'b1, 7, 1'b0, 1'b0);

        // Reset during channel 1 dwell aborts with no done.
        @(negedge clk);
        mask = 3'b111; settle = CW'(1); dwell = CW'(3); cont = 1'b0; start = 1'b1;
        s = cyc + 1;
        sq.push_back('{s: s, e: s + 15});
        for (int v = 0; v < 3; v++)
            for (int j = 0; j < 3; j++) vq.push_back('{cyc: s + v * 5 + 2 + TRIG_CYC + j, tag: v});
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 8 + TRIG_CYC) @(negedge clk);
        rst = 1'b1;
        sq.delete();
        vq.delete();
        @(posedge clk);
        #2;
        check("rst_sel", 32'(sel_o), 32'd0);
        check("rst_tag", 32'(tag_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_scan(3'b110, 0, 1, 1'b0, -1, 1'b0, 1'b0);

        // Randomized scans.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] m;
            bit c;
            int ss;
            m = N'($urandom_range(1, 7));
            c = 1'($urandom);
            ss = (c || ($urandom % 2) == 1) ? int'($urandom_range(0, 999)) : -1;
            run_scan(m, $urandom_range(0, 3), $urandom_range(0, 4), c, ss, 1'($urandom),
                     ($urandom % 5) == 0);
        end

        repeat (3) @(negedge clk);
        check("valid_queue_empty", 32'(vq.size()), 32'd0);
        check("scan_queue_empty", 32'(sq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
